// File: rtl/color_seq_ctrl.sv
// color_seq_ctrl: steps the colour detector through a target list and turns per-frame
// detections into motor commands. Build macro COLOR_SEQ_TIMEOUT_EN enables the per-colour search timeout.
module color_seq_ctrl #(
    parameter int LOCK_FRAMES   = 3,
    parameter int LOST_FRAMES   = 5,
    parameter int FRAME_TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_done,
    input  logic [2:0] detect_mode,
    input  logic       at_target,
    input  logic [7:0] color_list,
    input  logic [1:0] num_colors,
    output logic [1:0] color_mode,
    output logic [2:0] motor_cmd,
    output logic       locked,
    output logic       seq_done,
    output logic       busy
);

    // state  | meaning
    // IDLE   | waiting for start, motor stopped
    // SETTLE | colour just changed, dropping the stale frame
    // SEARCH | rotating, counting consecutive hits toward a lock
    // TRACK  | locked, steering from the detector, counting misses
    // DONE   | whole list visited, waiting for a restart
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SEARCH = 3'd2,
        S_TRACK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] M_STOP   = 3'd0;
    localparam logic [2:0] M_ROTATE = 3'd4;

    localparam int HIT_W  = $clog2(LOCK_FRAMES + 1);
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);
`ifdef COLOR_SEQ_TIMEOUT_EN
    localparam int FRM_W  = $clog2(FRAME_TIMEOUT + 1);
`endif

    state_t              r_state;
    logic [1:0]          r_idx;
    logic [1:0]          r_color;
    logic [2:0]          r_motor;
    logic                r_locked;
    logic                r_seq_done;
    logic                r_busy;
    logic [HIT_W-1:0]    r_hit_cnt;
    logic [MISS_W-1:0]   r_miss_cnt;
`ifdef COLOR_SEQ_TIMEOUT_EN
    logic [FRM_W-1:0]    r_frame_cnt;
`endif

    logic       w_hit;
    logic       w_lock;
    logic       w_last;
    logic [1:0] w_idx_next;
    logic [1:0] w_color_next;
    logic [2:0] w_track_cmd;

    // Codes 4-7 have bit 2 set and count as a miss.
    assign w_hit        = ~detect_mode[2] & (detect_mode[1:0] != 2'd0);
    assign w_track_cmd  = {1'b0, detect_mode[1:0]};
    assign w_lock       = w_hit && (r_hit_cnt == HIT_W'(LOCK_FRAMES - 1));
    assign w_last       = (r_idx == num_colors);
    assign w_idx_next   = w_last ? 2'd0 : r_idx + 2'd1;
    assign w_color_next = color_list[{w_idx_next, 1'b0} +: 2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_color     <= 2'd0;
            r_motor     <= M_STOP;
            r_locked    <= 1'b0;
            r_seq_done  <= 1'b0;
            r_busy      <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
`ifdef COLOR_SEQ_TIMEOUT_EN
            r_frame_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_SETTLE;
                        r_idx       <= 2'd0;
                        r_color     <= color_list[1:0];
                        r_motor     <= M_STOP;
                        r_locked    <= 1'b0;
                        r_seq_done  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_hit_cnt   <= '0;
                        r_miss_cnt  <= '0;
`ifdef COLOR_SEQ_TIMEOUT_EN
                        r_frame_cnt <= '0;
`endif
                    end
                end

                S_SETTLE: begin
                    if (frame_done) begin
                        r_state <= S_SEARCH;
                        r_motor <= M_ROTATE;
                    end
                end

                S_SEARCH: begin
                    if (frame_done) begin
                        if (w_lock) begin
                            r_state     <= S_TRACK;
                            r_locked    <= 1'b1;
                            r_motor     <= w_track_cmd;
                            r_hit_cnt   <= '0;
                            r_miss_cnt  <= '0;
`ifdef COLOR_SEQ_TIMEOUT_EN
                            r_frame_cnt <= '0;
                        end else if (r_frame_cnt == FRM_W'(FRAME_TIMEOUT - 1)) begin
                            r_state     <= S_SETTLE;
                            r_idx       <= w_idx_next;
                            r_color     <= w_color_next;
                            r_motor     <= M_STOP;
                            r_hit_cnt   <= '0;
                            r_miss_cnt  <= '0;
                            r_frame_cnt <= '0;
`endif
                        end else begin
                            r_hit_cnt   <= w_hit ? r_hit_cnt + HIT_W'(1) : '0;
`ifdef COLOR_SEQ_TIMEOUT_EN
                            r_frame_cnt <= r_frame_cnt + FRM_W'(1);
`endif
                        end
                    end
                end

                S_TRACK: begin
                    // Arrival outranks a frame result arriving in the same cycle.
                    if (at_target) begin
                        r_motor     <= M_STOP;
                        r_locked    <= 1'b0;
                        r_hit_cnt   <= '0;
                        r_miss_cnt  <= '0;
`ifdef COLOR_SEQ_TIMEOUT_EN
                        r_frame_cnt <= '0;
`endif
                        if (w_last) begin
                            r_state    <= S_DONE;
                            r_seq_done <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state <= S_SETTLE;
                            r_idx   <= w_idx_next;
                            r_color <= w_color_next;
                        end
                    end else if (frame_done) begin
                        if (w_hit) begin
                            r_motor    <= w_track_cmd;
                            r_miss_cnt <= '0;
                        end else if (r_miss_cnt == MISS_W'(LOST_FRAMES - 1)) begin
                            r_state     <= S_SEARCH;
                            r_locked    <= 1'b0;
                            r_motor     <= M_ROTATE;
                            r_hit_cnt   <= '0;
                            r_miss_cnt  <= '0;
`ifdef COLOR_SEQ_TIMEOUT_EN
                            r_frame_cnt <= '0;
`endif
                        end else begin
                            r_miss_cnt <= r_miss_cnt + MISS_W'(1);
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_motor    <= M_STOP;
                    r_locked   <= 1'b0;
                    r_seq_done <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign color_mode = r_color;
    assign motor_cmd  = r_motor;
    assign locked     = r_locked;
    assign seq_done   = r_seq_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_color_seq_ctrl.sv
// Scoreboard bench for color_seq_ctrl: the driver queues hand-computed outputs per cycle,
// a negedge monitor pops and compares them.
module tb_color_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       frame_done;
    logic [2:0] detect_mode;
    logic       at_target;
    logic [7:0] color_list;
    logic [1:0] num_colors;
    logic [1:0] color_mode;
    logic [2:0] motor_cmd;
    logic       locked;
    logic       seq_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    color_seq_ctrl #(
        .LOCK_FRAMES   (3),
        .LOST_FRAMES   (4),
        .FRAME_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .frame_done  (frame_done),
        .detect_mode (detect_mode),
        .at_target   (at_target),
        .color_list  (color_list),
        .num_colors  (num_colors),
        .color_mode  (color_mode),
        .motor_cmd   (motor_cmd),
        .locked      (locked),
        .seq_done    (seq_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected word per driven cycle, compared half a cycle after the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] a;
            e = exp_q.pop_front();
            a = {color_mode, motor_cmd, locked, seq_done, busy};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs check %0d at %0t: got cm=%0d mc=%0d lk=%b sd=%b bs=%b, expected cm=%0d mc=%0d lk=%b sd=%b bs=%b",
                         checks, $time, a[7:6], a[5:3], a[2], a[1], a[0],
                         e[7:6], e[5:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic step(input logic rst, input logic st, input logic fd,
                        input logic [2:0] dm, input logic at,
                        input logic [1:0] cm, input logic [2:0] mc,
                        input logic lk, input logic sd, input logic bs);
        @(negedge clk);
        reset       = rst;
        start       = st;
        frame_done  = fd;
        detect_mode = dm;
        at_target   = at;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        start      = 1'b0;
        frame_done = 1'b0;
        at_target  = 1'b0;
        exp_q.push_back({cm, mc, lk, sd, bs});
    endtask

    task automatic frame(input logic [2:0] dm, input logic [1:0] cm, input logic [2:0] mc,
                         input logic lk, input logic sd, input logic bs);
        step(1'b0, 1'b0, 1'b1, dm, 1'b0, cm, mc, lk, sd, bs);
    endtask

    initial begin
        int pat[8] = '{1, 1, 0, 1, 1, 0, 0, 0};
        int wait_cyc;
        reset       = 1'b1;
        start       = 1'b0;
        frame_done  = 1'b0;
        detect_mode = 3'd0;
        at_target   = 1'b0;
        color_list  = 8'b11_10_01_00;
        num_colors  = 2'd3;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);           // reset beats start
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);           // start -> SETTLE
        frame(1, 0, 4, 0, 0, 1);                      // stale frame dropped
        frame(1, 0, 4, 0, 0, 1);
        frame(1, 0, 4, 0, 0, 1);
        frame(1, 0, 1, 1, 0, 1);                      // third hit locks
        frame(2, 0, 2, 1, 0, 1);
        frame(3, 0, 3, 1, 0, 1);
        frame(0, 0, 3, 1, 0, 1);
        frame(0, 0, 3, 1, 0, 1);
        frame(2, 0, 2, 1, 0, 1);                      // hit clears miss count
        frame(0, 0, 2, 1, 0, 1);
        frame(7, 0, 2, 1, 0, 1);
        frame(0, 0, 2, 1, 0, 1);
        frame(4, 0, 4, 0, 0, 1);                      // fourth miss -> SEARCH

`ifdef COLOR_SEQ_TIMEOUT_EN
        for (int i = 0; i < 7; i++) frame(3'(pat[i]), 0, 4, 0, 0, 1);
        frame(3'(pat[7]), 1, 0, 0, 0, 1);             // timeout -> colour 1
        for (int c = 1; c < 4; c++) begin
            frame(0, 2'(c), 4, 0, 0, 1);
            for (int i = 0; i < 7; i++) frame(0, 2'(c), 4, 0, 0, 1);
            frame(0, 2'((c + 1) % 4), 0, 0, 0, 1);
        end
        frame(0, 0, 4, 0, 0, 1);
`else
        for (int i = 0; i < 8; i++) frame(3'(pat[i]), 0, 4, 0, 0, 1);
        for (int i = 0; i < 20; i++) frame(0, 0, 4, 0, 0, 1);
`endif

        step(0, 1, 0, 0, 0, 0, 4, 0, 0, 1);           // start ignored in SEARCH
        step(0, 0, 0, 0, 1, 0, 4, 0, 0, 1);           // at_target ignored in SEARCH

        frame(3, 0, 4, 0, 0, 1);
        frame(3, 0, 4, 0, 0, 1);
        frame(3, 0, 3, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        frame(0, 1, 4, 0, 0, 1);
        frame(2, 1, 4, 0, 0, 1);
        frame(2, 1, 4, 0, 0, 1);
        frame(2, 1, 2, 1, 0, 1);
        step(0, 0, 0, 0, 1, 2, 0, 0, 0, 1);
        frame(0, 2, 4, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1, 3, 0, 0, 0, 1);
        frame(0, 3, 4, 0, 0, 1);
        frame(1, 3, 4, 0, 0, 1);
        frame(1, 3, 4, 0, 0, 1);
        frame(1, 3, 1, 1, 0, 1);
        step(0, 0, 1, 2, 1, 3, 0, 0, 1, 0);           // at_target beats frame_done -> DONE
        step(0, 0, 1, 1, 1, 3, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);           // restart from DONE

        color_list = 8'b00_00_01_10;
        num_colors = 2'd1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 2, 0, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        frame(0, 1, 4, 0, 0, 1);
        frame(3, 1, 4, 0, 0, 1);
        frame(3, 1, 4, 0, 0, 1);
        frame(3, 1, 3, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);           // idx == num_colors -> DONE
        step(0, 1, 0, 0, 0, 2, 0, 0, 0, 1);
        frame(0, 2, 4, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 1, 1, 0, 1);
        step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);           // reset mid-TRACK
        step(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 2, 0, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);
        frame(1, 2, 4, 0, 0, 1);                      // no counts survived reset
        frame(1, 2, 1, 1, 0, 1);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
